// File: rtl/evu_event_stream_if.sv
// Configuration register port and record stream carried between evu_event_stream and its neighbours.
// Record stream: valid/ready; head data is held stable while valid is high and ready is low.
interface evu_cfg_if #(
    parameter int ADDR_W = 3
);
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;

    modport master (output we, addr, wdata, input rdata);
    modport slave  (input we, addr, wdata, output rdata);
endinterface

interface evu_rec_if #(
    parameter int NUM_CH = 4,
    parameter int INFO_W = 18
);
    logic              valid;
    logic              ready;
    logic [NUM_CH-1:0] eid;
    logic [INFO_W-1:0] info;

    modport master (output valid, eid, info, input ready);
    modport slave  (input valid, eid, info, output ready);
endinterface

// File: rtl/evu_event_stream.sv
// Event router: maps core event pulses onto channels (pass/prescale/edge) and queues one record per firing cycle.
// Latency 1 cycle from event to registered FIFO head; when the FIFO is full, records are dropped and counted.
module evu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_vld_i,
    input  logic [WIDTH-1:0]       push_dat_i,
    output logic                   push_acc_o,
    output logic                   pop_vld_o,
    input  logic                   pop_rdy_i,
    output logic [WIDTH-1:0]       pop_dat_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]            count_q, count_d;
    logic                        pop;
    logic                        push_acc;

    assign pop       = (count_q != '0) && pop_rdy_i;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_acc  = push_vld_i && !flush_i && ((count_q != OCC_W'(DEPTH)) || pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_acc) begin
                mem_d[wr_ptr_q] = push_dat_i;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + OCC_W'(push_acc) - OCC_W'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign push_acc_o = push_acc;
    assign pop_vld_o  = (count_q != '0);
    assign pop_dat_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o    = count_q;
endmodule

module evu_event_stream #(
    parameter int NUM_CH     = 4,
    parameter int NUM_EVENTS = 16,
    parameter int CNT_W      = 16,
    parameter int INFO_W     = 18,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_EVENTS-1:0] event_vec_i,
    input  logic [INFO_W-1:0]     info_i,
    evu_cfg_if.slave              cfg,
    evu_rec_if.master             rec
);
    localparam int SEL_W  = $clog2(NUM_EVENTS);
    localparam int ADDR_W = $clog2(NUM_CH + 2);
    localparam int OCC_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int REC_W  = NUM_CH + INFO_W;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_PASS  = 2'b01,
        MODE_PRESC = 2'b10,
        MODE_EDGE  = 2'b11
    } mode_e;

    logic [SEL_W-1:0] sel_q   [NUM_CH];
    logic [SEL_W-1:0] sel_d   [NUM_CH];
    mode_e            mode_q  [NUM_CH];
    mode_e            mode_d  [NUM_CH];
    logic [CNT_W-1:0] presc_q [NUM_CH];
    logic [CNT_W-1:0] presc_d [NUM_CH];
    logic [CNT_W-1:0] cnt_q   [NUM_CH];
    logic [CNT_W-1:0] cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] ev_prev_q, ev_prev_d;
    logic              enable_q, enable_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic [NUM_CH-1:0] ev_sel;
    logic [NUM_CH-1:0] fire;
    logic              wr_status;
    logic              wr_gctrl;
    logic              flush;
    logic              push_acc;
    logic [OCC_W-1:0]  occ;
    logic [REC_W-1:0]  head_dat;
    logic [31:0]       cfg_rdata;

    // N=0 behaves as N=1, so the terminal count is N-1 clamped at zero.
    function automatic logic [CNT_W-1:0] presc_last(input logic [CNT_W-1:0] n);
        return (n == '0) ? '0 : n - 1'b1;
    endfunction

    assign wr_status = cfg.we && (cfg.addr == ADDR_W'(NUM_CH));
    assign wr_gctrl  = cfg.we && (cfg.addr == ADDR_W'(NUM_CH + 1));
    assign flush     = wr_gctrl && cfg.wdata[1];

    always_comb begin
        ev_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (32'(sel_q[c]) < NUM_EVENTS) begin
                ev_sel[c] = event_vec_i[sel_q[c]];
            end
        end
    end

    always_comb begin
        fire      = '0;
        ev_prev_d = ev_prev_q;
        for (int c = 0; c < NUM_CH; c++) begin
            sel_d[c]   = sel_q[c];
            mode_d[c]  = mode_q[c];
            presc_d[c] = presc_q[c];
            cnt_d[c]   = cnt_q[c];
            // A CTRL write to this channel overrides any event arriving in the same cycle.
            if (cfg.we && (cfg.addr == ADDR_W'(c))) begin
                sel_d[c]     = cfg.wdata[SEL_W-1:0];
                mode_d[c]    = mode_e'(cfg.wdata[9:8]);
                presc_d[c]   = cfg.wdata[16 +: CNT_W];
                cnt_d[c]     = '0;
                ev_prev_d[c] = 1'b0;
            end else if (enable_q && (mode_q[c] != MODE_OFF)) begin
                ev_prev_d[c] = ev_sel[c];
                case (mode_q[c])
                    MODE_PASS: fire[c] = ev_sel[c];
                    MODE_PRESC: begin
                        if (ev_sel[c]) begin
                            if (cnt_q[c] == presc_last(presc_q[c])) begin
                                fire[c]  = 1'b1;
                                cnt_d[c] = '0;
                            end else begin
                                cnt_d[c] = cnt_q[c] + 1'b1;
                            end
                        end
                    end
                    MODE_EDGE: fire[c] = ev_sel[c] & ~ev_prev_q[c];
                    default: fire[c] = 1'b0;
                endcase
            end
        end
    end

    always_comb begin
        enable_d   = wr_gctrl ? cfg.wdata[0] : enable_q;
        drop_cnt_d = drop_cnt_q;
        if (wr_status) begin
            drop_cnt_d = '0;
        end else if ((|fire) && !push_acc && !flush && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_comb begin
        cfg_rdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cfg.addr == ADDR_W'(c)) begin
                cfg_rdata[SEL_W-1:0]    = sel_q[c];
                cfg_rdata[9:8]          = mode_q[c];
                cfg_rdata[16 +: CNT_W]  = presc_q[c];
            end
        end
        if (cfg.addr == ADDR_W'(NUM_CH)) begin
            cfg_rdata[15:0]        = drop_cnt_q;
            cfg_rdata[16 +: OCC_W] = occ;
        end
        if (cfg.addr == ADDR_W'(NUM_CH + 1)) begin
            cfg_rdata[0] = enable_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enable_q   <= 1'b0;
            drop_cnt_q <= '0;
            ev_prev_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                sel_q[c]   <= '0;
                mode_q[c]  <= MODE_OFF;
                presc_q[c] <= '0;
                cnt_q[c]   <= '0;
            end
        end else begin
            enable_q   <= enable_d;
            drop_cnt_q <= drop_cnt_d;
            ev_prev_q  <= ev_prev_d;
            for (int c = 0; c < NUM_CH; c++) begin
                sel_q[c]   <= sel_d[c];
                mode_q[c]  <= mode_d[c];
                presc_q[c] <= presc_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
        end
    end

    evu_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rec_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush),
        .push_vld_i (|fire),
        .push_dat_i ({fire, info_i}),
        .push_acc_o (push_acc),
        .pop_vld_o  (rec.valid),
        .pop_rdy_i  (rec.ready),
        .pop_dat_o  (head_dat),
        .count_o    (occ)
    );

    assign rec.eid   = head_dat[REC_W-1:INFO_W];
    assign rec.info  = head_dat[INFO_W-1:0];
    assign cfg.rdata = cfg_rdata;
endmodule

// File: tb/tb_evu_event_stream.sv
// Directed bench for evu_event_stream: 4 channels, 12 events, 4-deep record FIFO.
module tb_evu_event_stream;
    localparam int NUM_CH     = 4;
    localparam int NUM_EVENTS = 12;
    localparam int CNT_W      = 16;
    localparam int INFO_W     = 18;
    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 3;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic [NUM_EVENTS-1:0] event_vec_i;
    logic [INFO_W-1:0]     info_i;
    int                    n_vec = 0;
    int                    n_err = 0;
    int                    n_rec;

    evu_cfg_if #(.ADDR_W(ADDR_W)) cfg_if ();
    evu_rec_if #(.NUM_CH(NUM_CH), .INFO_W(INFO_W)) rec_if ();

    evu_event_stream #(
        .NUM_CH     (NUM_CH),
        .NUM_EVENTS (NUM_EVENTS),
        .CNT_W      (CNT_W),
        .INFO_W     (INFO_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .event_vec_i (event_vec_i),
        .info_i      (info_i),
        .cfg         (cfg_if.slave),
        .rec         (rec_if.master)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cfg_wr(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
        cfg_if.we    = 1'b1;
        cfg_if.addr  = addr;
        cfg_if.wdata = data;
        tick();
        cfg_if.we    = 1'b0;
        cfg_if.wdata = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [ADDR_W-1:0] addr, input logic [31:0] exp);
        cfg_if.addr = addr;
        #1;
        chk(tag, cfg_if.rdata, exp);
    endtask

    task automatic pulse(input logic [NUM_EVENTS-1:0] ev, input logic [INFO_W-1:0] info);
        event_vec_i = ev;
        info_i      = info;
        tick();
        event_vec_i = '0;
        info_i      = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i        = 1'b1;
        event_vec_i  = '0;
        info_i       = '0;
        cfg_if.we    = 1'b0;
        cfg_if.addr  = '0;
        cfg_if.wdata = '0;
        rec_if.ready = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;

        chk("rst_vld", 32'(rec_if.valid), 32'd0);
        chk("rst_eid", 32'(rec_if.eid), 32'd0);
        chk("rst_info", 32'(rec_if.info), 32'd0);
        rd_chk("rst_status", 3'd4, 32'h0);
        rd_chk("rst_gctrl", 3'd5, 32'h0);
        rd_chk("rst_ctrl0", 3'd0, 32'h0);

        // pass-through on event 3
        cfg_wr(3'd0, 32'h0000_0103);
        cfg_wr(3'd5, 32'h1);
        rd_chk("ctrl0_rb", 3'd0, 32'h0000_0103);
        rd_chk("gctrl_rb", 3'd5, 32'h1);
        pulse(12'h008, 18'h155);
        chk("pass_vld", 32'(rec_if.valid), 32'd1);
        chk("pass_eid", 32'(rec_if.eid), 32'h1);
        chk("pass_info", 32'(rec_if.info), 32'h155);
        tick();
        chk("pass_vld_t2", 32'(rec_if.valid), 32'd0);
        chk("pass_eid_t2", 32'(rec_if.eid), 32'd0);

        // back-to-back records with ready held high
        for (int i = 0; i < 4; i++) begin
            event_vec_i = 12'h008;
            info_i      = 18'(32'h40 + i);
            tick();
            chk("thru_vld", 32'(rec_if.valid), 32'd1);
            chk("thru_info", 32'(rec_if.info), 32'h40 + i);
        end
        event_vec_i = '0;
        info_i      = '0;
        tick();
        chk("thru_drain", 32'(rec_if.valid), 32'd0);
        rd_chk("thru_status", 3'd4, 32'h0);

        // prescale by 3 on event 5
        cfg_wr(3'd1, 32'h0003_0205);
        rd_chk("ctrl1_rb", 3'd1, 32'h0003_0205);
        for (int p = 1; p <= 7; p++) begin
            pulse(12'h020, '0);
            chk("presc_vld", 32'(rec_if.valid), (p % 3 == 0) ? 32'd1 : 32'd0);
            if (p % 3 == 0) chk("presc_eid", 32'(rec_if.eid), 32'h2);
            tick();
        end
        cfg_wr(3'd1, 32'h0003_0205);
        for (int p = 1; p <= 3; p++) begin
            pulse(12'h020, '0);
            chk("presc_rewr_vld", 32'(rec_if.valid), (p == 3) ? 32'd1 : 32'd0);
            tick();
        end

        // rising edge on event 0 held high for 5 cycles
        cfg_wr(3'd2, 32'h0000_0300);
        n_rec = 0;
        event_vec_i = 12'h001;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rec_if.valid) begin
                n_rec++;
                chk("edge_eid", 32'(rec_if.eid), 32'h4);
            end
        end
        event_vec_i = '0;
        tick();
        if (rec_if.valid) n_rec++;
        chk("edge_count", 32'(n_rec), 32'd1);

        // overflow: 6 fires into a 4-deep FIFO with ready low
        rec_if.ready = 1'b0;
        for (int i = 0; i < 6; i++) pulse(12'h008, 18'(32'h10 + i));
        rd_chk("ovf_status", 3'd4, 32'h0004_0002);
        chk("ovf_vld", 32'(rec_if.valid), 32'd1);
        chk("ovf_eid", 32'(rec_if.eid), 32'h1);
        chk("ovf_head", 32'(rec_if.info), 32'h10);
        rec_if.ready = 1'b1;
        pulse(12'h008, 18'h20);
        rec_if.ready = 1'b0;
        rd_chk("full_pushpop_status", 3'd4, 32'h0004_0002);
        chk("full_pushpop_head", 32'(rec_if.info), 32'h11);

        // flush with 3 queued and a same-cycle fire
        rec_if.ready = 1'b1;
        tick();
        rec_if.ready = 1'b0;
        rd_chk("preflush_status", 3'd4, 32'h0003_0002);
        chk("preflush_head", 32'(rec_if.info), 32'h12);
        event_vec_i = 12'h008;
        info_i      = 18'h30;
        cfg_wr(3'd5, 32'h3);
        event_vec_i = '0;
        info_i      = '0;
        chk("flush_vld", 32'(rec_if.valid), 32'd0);
        chk("flush_info", 32'(rec_if.info), 32'd0);
        rd_chk("flush_status", 3'd4, 32'h0000_0002);
        rd_chk("flush_gctrl", 3'd5, 32'h1);
        cfg_wr(3'd4, 32'hFFFF_FFFF);
        rd_chk("drop_clear", 3'd4, 32'h0);

        // CTRL write coincident with an event wins
        rec_if.ready = 1'b1;
        event_vec_i  = 12'h008;
        cfg_wr(3'd0, 32'h0000_0103);
        event_vec_i  = '0;
        chk("wrwin_vld", 32'(rec_if.valid), 32'd0);
        pulse(12'h008, 18'h77);
        chk("wrwin_after_vld", 32'(rec_if.valid), 32'd1);
        chk("wrwin_after_info", 32'(rec_if.info), 32'h77);
        tick();

        // sel beyond NUM_EVENTS never fires
        cfg_wr(3'd0, 32'h0);
        cfg_wr(3'd1, 32'h0);
        cfg_wr(3'd2, 32'h0);
        cfg_wr(3'd3, 32'h0000_010E);
        rd_chk("ctrl3_rb", 3'd3, 32'h0000_010E);
        event_vec_i = 12'hFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("oor_vld", 32'(rec_if.valid), 32'd0);
        end
        event_vec_i = '0;

        // reset while two records are queued
        cfg_wr(3'd0, 32'h0000_0103);
        rec_if.ready = 1'b0;
        pulse(12'h008, 18'h2A);
        pulse(12'h008, 18'h2B);
        rd_chk("prerst_status", 3'd4, 32'h0002_0000);
        chk("prerst_head", 32'(rec_if.info), 32'h2A);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("mrst_vld", 32'(rec_if.valid), 32'd0);
        chk("mrst_eid", 32'(rec_if.eid), 32'd0);
        chk("mrst_info", 32'(rec_if.info), 32'd0);
        rd_chk("mrst_status", 3'd4, 32'h0);
        rd_chk("mrst_gctrl", 3'd5, 32'h0);
        rd_chk("mrst_ctrl0", 3'd0, 32'h0);
        pulse(12'h008, 18'h3C);
        chk("mrst_disabled_vld", 32'(rec_if.valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
